// File: rtl/bist_controller.sv
// BIST sequencer: seeds the TPG, clears the MISR, runs a fixed number of
// patterns through the full-adder CUT and grades the final signature.
module bist_controller #(
   parameter int                   PATTERN_COUNT = 8,
   parameter int                   CNT_WIDTH     = 4,
   parameter int                   SIG_WIDTH     = 4,
   parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = 4'b1010
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [SIG_WIDTH-1:0] ora_signature,
   output logic                 tpg_load,
   output logic                 ora_clear,
   output logic                 tpg_enable,
   output logic                 ora_enable,
   output logic                 test_mode,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [CNT_WIDTH-1:0] pattern_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_COMPARE,
      S_DONE
   } state_t;

   // Terminal compare, so a full 2**CNT_WIDTH run never relies on wrap.
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PATTERN_COUNT - 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 pass_q, pass_d;
   logic                 fail_q, fail_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_INIT;
         S_INIT:    state_d = S_RUN;
         S_RUN:     if (cnt_q == LAST_IDX) state_d = S_COMPARE;
         S_COMPARE: state_d = S_DONE;
         S_DONE:    if (start) state_d = S_INIT;
         default:   state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Counter only lives inside RUN, so it reads as zero everywhere else.
   always_comb begin
      cnt_d  = '0;
      pass_d = pass_q;
      fail_d = fail_q;
      if (state_q == S_RUN && state_d == S_RUN) cnt_d = cnt_q + 1'b1;
      if (state_q == S_COMPARE && state_d == S_DONE) begin
         pass_d = (ora_signature == GOLDEN_SIG);
         fail_d = (ora_signature != GOLDEN_SIG);
      end else if (state_d != S_DONE) begin
         pass_d = 1'b0;
         fail_d = 1'b0;
      end
   end

   always_comb begin
      tpg_load    = (state_q == S_INIT);
      ora_clear   = (state_q == S_INIT);
      tpg_enable  = (state_q == S_RUN);
      ora_enable  = (state_q == S_RUN);
      test_mode   = (state_q == S_INIT) || (state_q == S_RUN) ||
                    (state_q == S_COMPARE);
      busy        = test_mode;
      done        = (state_q == S_DONE);
      pass        = pass_q;
      fail        = fail_q;
      pattern_idx = cnt_q;
   end

endmodule

// File: tb/tb_bist_controller.sv
// Randomised scoreboard bench for bist_controller: a run-timeline model
// predicts every output after each edge, a monitor compares.
module tb_bist_controller;

   localparam int         P    = 8;
   localparam logic [3:0] GOLD = 4'b1010;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic [3:0] ora_signature;
   logic       tpg_load, ora_clear, tpg_enable, ora_enable;
   logic       test_mode, busy, done, pass, fail;
   logic [3:0] pattern_idx;

   int checks = 0;
   int errors = 0;

   // k = cycles since the run was accepted (0 = idle); mv = last verdict
   int   mk = 0;
   bit   mv = 1'b0;
   logic [12:0] exp_q[$];
   event exp_ev;

   bist_controller dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .ora_signature(ora_signature),
      .tpg_load(tpg_load), .ora_clear(ora_clear),
      .tpg_enable(tpg_enable), .ora_enable(ora_enable),
      .test_mode(test_mode), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .pattern_idx(pattern_idx)
   );

   always #5 clock = ~clock;

   function automatic logic [12:0] expect_of(int k, bit v);
      bit run, act, dn;
      logic [3:0] idx;
      run = (k >= 2) && (k <= P + 1);
      act = (k >= 1) && (k <= P + 2);
      dn  = (k >= P + 3);
      idx = run ? 4'(k - 2) : 4'd0;
      return {k == 1, k == 1, run, run, act, act, dn, dn && v, dn && !v, idx};
   endfunction

   function automatic logic [12:0] dut_vec();
      return {tpg_load, ora_clear, tpg_enable, ora_enable, test_mode,
              busy, done, pass, fail, pattern_idx};
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mk = 0;
         mv = 1'b0;
      end else if (mk == 0) begin
         if (start && !abort) mk = 1;
      end else if (abort) begin
         mk = 0;
      end else if (mk >= P + 3) begin
         if (start) mk = 1;
      end else begin
         if (mk == P + 2) mv = (ora_signature == GOLD);
         mk = mk + 1;
      end
      exp_q.push_back(expect_of(mk, mv));
      -> exp_ev;
   end

   initial begin
      logic [12:0] e, g;
      forever begin
         @(exp_ev);
         #1;
         checks++;
         g = dut_vec();
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got %b", $time, g);
         end else begin
            e = exp_q.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL outs t=%0t got %b exp %b (load,clr,tpg,ora,tm,busy,done,pass,fail,idx)",
                        $time, g, e);
            end
         end
      end
   end

   task automatic direct_zero(string name);
      checks++;
      if (dut_vec() !== 13'd0) begin
         errors++;
         $display("FAIL %s t=%0t got %b exp 0", name, $time, dut_vec());
      end
   endtask

   task automatic cycles(int n, logic [3:0] target);
      repeat (n) begin
         @(negedge clock);
         start = 1'b0;
         abort = 1'b0;
         ora_signature = (mk == P + 2) ? target : 4'($urandom);
      end
   endtask

   task automatic wait_k(int target);
      bit hit = 1'b0;
      for (int i = 0; i < 64 && !hit; i++) begin
         @(negedge clock);
         start = 1'b0;
         abort = 1'b0;
         ora_signature = 4'($urandom);
         hit = (mk == target);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wait_k%0d timeout got %0d exp %0d", target, mk, target);
      end
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      ora_signature = 4'd0;
      #1 direct_zero("reset_no_clock");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      cycles(3, GOLD);

      // pass run, then fail run restarted from DONE and held
      pulse_start();
      cycles(12, GOLD);
      pulse_start();
      cycles(30, 4'b1011);

      // start while busy is ignored, then restart from DONE
      pulse_start();
      wait_k(5);
      start = 1'b1;
      cycles(14, GOLD);
      pulse_start();
      cycles(12, 4'b1011);

      // abort mid-run, then start+abort together in DONE and IDLE
      pulse_start();
      wait_k(7);
      abort = 1'b1;
      cycles(3, GOLD);
      pulse_start();
      cycles(12, GOLD);
      @(negedge clock);
      start = 1'b1;
      abort = 1'b1;
      cycles(2, GOLD);
      @(negedge clock);
      start = 1'b1;
      abort = 1'b1;
      cycles(2, GOLD);

      // asynchronous reset pulse between edges during RUN
      pulse_start();
      wait_k(4);
      #2 reset = 1'b1;
      #1 direct_zero("async_reset");
      #2 reset = 1'b0;
      pulse_start();
      cycles(12, GOLD);

      // random soak
      repeat (600) begin
         @(negedge clock);
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 31) == 0);
         if (mk == P + 2 && $urandom_range(0, 1) == 1)
            ora_signature = GOLD;
         else
            ora_signature = 4'($urandom);
      end
      cycles(2, GOLD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
Top-level BIST sequencer for the 1-bit full-adder test structure. It clears and seeds the test pattern generator (LFSR) and the 4-bit MISR output response analyser (ORA), and drives the CUT input mux into test mode. It then runs a fixed number of patterns, compares the final MISR signature against a golden value, and reports pass or fail. It sits between system control (start/abort) and the TPG, CUT-mux and ORA instances.

Parameters:
PATTERN_COUNT, 8, number of clock cycles the TPG/ORA are enabled (patterns compacted); legal range 1..2**CNT_WIDTH.
CNT_WIDTH, 4, width of the pattern counter and pattern_idx port.
SIG_WIDTH, 4, MISR signature width.
GOLDEN_SIG, 4'b1010, expected fault-free MISR signature after PATTERN_COUNT patterns.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  level-sampled request to begin a BIST run.
abort  input  1  synchronous abort; returns to IDLE.
ora_signature  input  SIG_WIDTH  current MISR contents (dataout_ora of the ORA).
tpg_load  output  1  one-cycle synchronous seed load for the TPG.
ora_clear  output  1  one-cycle synchronous clear for the MISR.
tpg_enable  output  1  TPG advances one pattern per cycle while high.
ora_enable  output  1  MISR compacts CUT outputs (Sum,Cout) while high.
test_mode  output  1  CUT input mux select: 1 = TPG patterns, 0 = functional inputs.
busy  output  1  high in INIT, RUN and COMPARE.
done  output  1  high in DONE.
pass  output  1  valid while done is high: signature matched.
fail  output  1  valid while done is high: signature mismatched.
pattern_idx  output  CNT_WIDTH  index of the pattern currently applied in RUN.

Behaviour:
- Reset (async, active-high): state=IDLE; counter=0; every output is 0.
- All outputs are registered or decoded from registered state only; there are no combinational input-to-output paths.
- States: IDLE, INIT, RUN, COMPARE, DONE.
- IDLE: all control outputs are 0. If start=1 at a rising edge, go to INIT.
- INIT (exactly 1 cycle): tpg_load=1, ora_clear=1, test_mode=1, busy=1; counter is cleared to 0. Next state is RUN.
- RUN: tpg_enable=1, ora_enable=1, test_mode=1, busy=1, pattern_idx=counter.
  - At each edge the counter increments.
  - When counter==PATTERN_COUNT-1 at an edge, go to COMPARE.
  - RUN therefore lasts exactly PATTERN_COUNT cycles.
- COMPARE (exactly 1 cycle): tpg_enable=0, ora_enable=0, test_mode=1, busy=1.
  - At the edge leaving COMPARE, pass <= (ora_signature==GOLDEN_SIG) and fail <= ~pass-condition.
  - Next state is DONE.
- DONE: done=1, busy=0, test_mode=0. pass/fail hold their values.
  - start=1 restarts (go to INIT); pass/fail/done clear on that transition.
  - Otherwise remain in DONE indefinitely.
- Latency: if start is sampled at edge E, done rises after edge E+PATTERN_COUNT+2 (edge E+10 for the defaults).
- start while busy: ignored; no restart and no state change.
- abort=1 in any state other than IDLE: at the next edge go to IDLE and clear all outputs and the counter. abort takes priority over start and over normal transitions, including the COMPARE->DONE transition.
- Simultaneous start=1 and abort=1 in IDLE or DONE: abort wins and the next state is IDLE.
- pass and fail are never both 1. Both are 0 whenever done=0.
- Counter is CNT_WIDTH bits wide; it never wraps during a legal run. PATTERN_COUNT=2**CNT_WIDTH is handled by the terminal compare, not by overflow.
- Async reset mid-run: immediate return to IDLE with all outputs 0, regardless of clock.

Test Plan:
- Reset: assert reset=1 at time 0 with no clock edges -> all outputs 0; release reset, run 3 idle cycles -> state remains IDLE, busy=0, done=0.
- Pass run: one-cycle start pulse; the ORA stub drives ora_signature=4'b1010 from COMPARE onward -> tpg_load/ora_clear high for 1 cycle, tpg_enable high for exactly 8 cycles with pattern_idx 0..7, done=1 and pass=1, fail=0 after the 10th edge.
- Fail run: same stimulus with ora_signature=4'b1011 -> done=1, pass=0, fail=1 after the 10th edge; the DONE state holds for 20 further cycles.
- Start ignored while busy, then restart: pulse start again at pattern_idx=3 -> no change and still exactly 8 RUN cycles; then pulse start while in DONE -> done/pass clear and INIT is re-entered on the next edge.
- Abort: assert abort at pattern_idx=5 -> the next edge gives IDLE with all outputs 0; start and abort together in DONE -> IDLE.
- Async reset mid-run: pulse reset=1 for 3 ns between clock edges during RUN -> outputs go to 0 immediately without a clock edge; a subsequent start begins a fresh run that completes in 10 edges.
